// File: rtl/otbn_edn_arb.sv
// otbn_edn_arb: arbitrates one EDN endpoint between RND and URND, packs eight EDN words
// into one WLEN word and hands it to the granted requester with a one-cycle ack.
module otbn_edn_arb #(
    parameter int WLEN         = 256,
    parameter int EdnWordWidth = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    rnd_req_i,
    output logic                    rnd_ack_o,
    output logic [WLEN-1:0]         rnd_data_o,
    input  logic                    urnd_req_i,
    output logic                    urnd_ack_o,
    output logic [WLEN-1:0]         urnd_data_o,
    output logic                    edn_req_o,
    input  logic                    edn_ack_i,
    input  logic [EdnWordWidth-1:0] edn_data_i
);
    localparam int NWords = WLEN / EdnWordWidth;
    localparam int CntW   = $clog2(NWords);

    typedef enum logic [1:0] {IDLE, FILL, ACK} state_e;

    state_e            r_state;
    logic              r_grant;
    logic              r_last;
    logic              r_edn_req;
    logic              r_rnd_ack;
    logic              r_urnd_ack;
    logic [CntW-1:0]   r_cnt;
    logic [WLEN-1:0]   r_buf;
    logic              w_hs;
    logic              w_last_word;
    logic              w_gnt_urnd;

    assign w_hs        = (r_state == FILL) && edn_ack_i;
    assign w_last_word = w_hs && (r_cnt == CntW'(NWords - 1));
    // r_grant/r_last: 0 = RND, 1 = URND; on a tie the one not served last wins
    assign w_gnt_urnd  = urnd_req_i && !(rnd_req_i && r_last);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_grant    <= 1'b0;
            r_last     <= 1'b1;
            r_edn_req  <= 1'b0;
            r_rnd_ack  <= 1'b0;
            r_urnd_ack <= 1'b0;
            r_cnt      <= '0;
            r_buf      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (rnd_req_i || urnd_req_i) begin
                        r_state   <= FILL;
                        r_grant   <= w_gnt_urnd;
                        r_edn_req <= 1'b1;
                    end
                end
                FILL: begin
                    if (w_hs) begin
                        r_buf[int'(r_cnt)*EdnWordWidth +: EdnWordWidth] <= edn_data_i;
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (w_last_word) begin
                        r_state    <= ACK;
                        r_edn_req  <= 1'b0;
                        r_rnd_ack  <= !r_grant;
                        r_urnd_ack <= r_grant;
                    end
                end
                ACK: begin
                    r_state    <= IDLE;
                    r_rnd_ack  <= 1'b0;
                    r_urnd_ack <= 1'b0;
                    r_last     <= r_grant;
                    r_buf      <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign edn_req_o   = r_edn_req;
    assign rnd_ack_o   = r_rnd_ack;
    assign urnd_ack_o  = r_urnd_ack;
    assign rnd_data_o  = (r_state == ACK) ? r_buf : '0;
    assign urnd_data_o = (r_state == ACK) ? r_buf : '0;

    a_one_ack: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(rnd_ack_o && urnd_ack_o));
    a_req_in_fill: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (r_state == FILL) |-> edn_req_o);
    a_rnd_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (r_state == FILL && !r_grant) |-> rnd_req_i);
    a_urnd_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (r_state == FILL && r_grant) |-> urnd_req_i);
endmodule

// File: tb/tb_otbn_edn_arb.sv
// tb_otbn_edn_arb: directed bench with a queue-based transaction model checked every cycle.
module tb_otbn_edn_arb;
    localparam int WLEN = 256;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            rnd_req_i = 1'b0;
    logic            urnd_req_i = 1'b0;
    logic            edn_ack_i = 1'b0;
    logic [31:0]     edn_data_i = '0;
    logic            rnd_ack_o;
    logic            urnd_ack_o;
    logic            edn_req_o;
    logic [WLEN-1:0] rnd_data_o;
    logic [WLEN-1:0] urnd_data_o;

    otbn_edn_arb dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .rnd_req_i  (rnd_req_i),
        .rnd_ack_o  (rnd_ack_o),
        .rnd_data_o (rnd_data_o),
        .urnd_req_i (urnd_req_i),
        .urnd_ack_o (urnd_ack_o),
        .urnd_data_o(urnd_data_o),
        .edn_req_o  (edn_req_o),
        .edn_ack_i  (edn_ack_i),
        .edn_data_i (edn_data_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_rnd = 0;
    int n_urnd = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Transaction model: a fill collects 8 accepted words, then one ack cycle shows them
    logic        m_fill;
    logic        m_ack;
    logic        m_who;
    logic        m_last;
    logic [31:0] m_words[$];

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_fill <= 1'b0;
            m_ack  <= 1'b0;
            m_who  <= 1'b0;
            m_last <= 1'b1;
            m_words.delete();
        end else if (m_ack) begin
            m_ack  <= 1'b0;
            m_last <= m_who;
            m_words.delete();
        end else if (m_fill) begin
            if (edn_ack_i) begin
                m_words.push_back(edn_data_i);
                if (m_words.size() == 8) begin
                    m_fill <= 1'b0;
                    m_ack  <= 1'b1;
                end
            end
        end else if (rnd_req_i || urnd_req_i) begin
            m_fill <= 1'b1;
            m_who  <= (rnd_req_i && urnd_req_i) ? !m_last : urnd_req_i;
        end
    end

    function automatic logic [WLEN-1:0] exp_data();
        logic [WLEN-1:0] d = '0;
        if (m_ack)
            for (int i = 0; i < m_words.size(); i++) d[i*32 +: 32] = m_words[i];
        return d;
    endfunction

    task automatic chk(input string name, input logic [WLEN-1:0] act, input logic [WLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        chk("edn_req", WLEN'(edn_req_o), WLEN'(m_fill));
        chk("rnd_ack", WLEN'(rnd_ack_o), WLEN'(m_ack && !m_who));
        chk("urnd_ack", WLEN'(urnd_ack_o), WLEN'(m_ack && m_who));
        chk("rnd_data", rnd_data_o, exp_data());
        chk("urnd_data", urnd_data_o, exp_data());
        if (rnd_ack_o) n_rnd++;
        if (urnd_ack_o) n_urnd++;
    end

    int              c0;
    int              f_lat;
    int              f_abs;
    logic            f_who;
    logic [WLEN-1:0] f_data;

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic feed(input logic [31:0] base, input int gap);
        for (int i = 0; i < 8; i++) begin
            if (i > 0)
                repeat (gap) begin
                    edn_ack_i = 1'b0;
                    step();
                end
            edn_ack_i  = 1'b1;
            edn_data_i = base + 32'(i);
            step();
        end
        edn_ack_i = 1'b0;
    endtask

    task automatic wait_edn_req();
        for (int k = 0; k < 20 && !edn_req_o; k++) step();
        chk("edn_req_timeout", WLEN'(edn_req_o), WLEN'(1));
    endtask

    task automatic wait_ack();
        for (int k = 0; k < 40 && !(rnd_ack_o || urnd_ack_o); k++) step();
        chk("ack_timeout", WLEN'(rnd_ack_o || urnd_ack_o), WLEN'(1));
    endtask

    task automatic fill(input logic r, input logic u, input logic [31:0] base, input int gap, input logic keep);
        rnd_req_i  = r;
        urnd_req_i = u;
        c0 = cyc;
        wait_edn_req();
        feed(base, gap);
        wait_ack();
        f_lat  = cyc - c0;
        f_abs  = cyc;
        f_who  = urnd_ack_o;
        f_data = urnd_ack_o ? urnd_data_o : rnd_data_o;
        if (!keep) begin
            rnd_req_i  = 1'b0;
            urnd_req_i = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1;
        int nr0;
        int nu0;
        #1;
        chk("rst_edn_req", WLEN'(edn_req_o), '0);
        chk("rst_rnd_ack", WLEN'(rnd_ack_o), '0);
        chk("rst_urnd_data", urnd_data_o, '0);
        step();
        rst_ni = 1'b1;
        step();

        fill(1'b1, 1'b0, 32'h0, 0, 1'b0);
        chk("single_lat", WLEN'(f_lat), WLEN'(9));
        chk("single_who", WLEN'(f_who), WLEN'(0));
        chk("single_data", f_data,
            256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000);
        step();
        chk("single_data_cleared", rnd_data_o, '0);
        chk("single_no_urnd", WLEN'(n_urnd), '0);

        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        fill(1'b1, 1'b1, 32'h10, 0, 1'b1);
        chk("tie1_who", WLEN'(f_who), WLEN'(0));
        fill(1'b1, 1'b1, 32'h20, 0, 1'b1);
        chk("tie2_who", WLEN'(f_who), WLEN'(1));
        chk("tie2_word0", WLEN'(f_data[31:0]), WLEN'(32'h20));
        chk("tie2_word7", WLEN'(f_data[255:224]), WLEN'(32'h27));
        fill(1'b1, 1'b1, 32'h30, 0, 1'b0);
        chk("tie3_who", WLEN'(f_who), WLEN'(0));

        step();
        fill(1'b1, 1'b0, 32'hA5A5A5A5, 2, 1'b0);
        chk("stall_lat", WLEN'(f_lat), WLEN'(23));
        chk("stall_data", f_data,
            256'hA5A5A5AC_A5A5A5AB_A5A5A5AA_A5A5A5A9_A5A5A5A8_A5A5A5A7_A5A5A5A6_A5A5A5A5);

        step();
        edn_ack_i  = 1'b1;
        edn_data_i = 32'hDEADBEEF;
        repeat (3) step();
        edn_ack_i = 1'b0;
        fill(1'b1, 1'b0, 32'h100, 0, 1'b0);
        chk("spurious_data", f_data,
            256'h00000107_00000106_00000105_00000104_00000103_00000102_00000101_00000100);

        step();
        rnd_req_i = 1'b1;
        wait_edn_req();
        for (int i = 0; i < 4; i++) begin
            edn_ack_i  = 1'b1;
            edn_data_i = 32'h200 + 32'(i);
            step();
        end
        edn_ack_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        chk("midrst_edn_req", WLEN'(edn_req_o), '0);
        chk("midrst_rnd_ack", WLEN'(rnd_ack_o), '0);
        chk("midrst_data", rnd_data_o, '0);
        rnd_req_i = 1'b0;
        step();
        rst_ni = 1'b1;
        nr0 = n_rnd;
        nu0 = n_urnd;
        fill(1'b0, 1'b1, 32'h300, 0, 1'b0);
        step();
        step();
        chk("midrst_urnd_once", WLEN'(n_urnd - nu0), WLEN'(1));
        chk("midrst_no_rnd", WLEN'(n_rnd - nr0), '0);
        chk("midrst_data_new", f_data,
            256'h00000307_00000306_00000305_00000304_00000303_00000302_00000301_00000300);

        nr0 = n_rnd;
        nu0 = n_urnd;
        fill(1'b0, 1'b1, 32'h400, 0, 1'b1);
        a1 = f_abs;
        fill(1'b0, 1'b1, 32'h500, 0, 1'b0);
        chk("b2b_spacing", WLEN'(f_abs - a1), WLEN'(10));
        chk("b2b_word0", WLEN'(f_data[31:0]), WLEN'(32'h500));
        step();
        step();
        chk("b2b_urnd_count", WLEN'(n_urnd - nu0), WLEN'(2));
        chk("b2b_no_rnd", WLEN'(n_rnd - nr0), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/otbn_edn_arb.md
# otbn_edn_arb

Shared EDN front-end for OTBN's random-number logic. Arbitrates one 32-bit EDN endpoint between the RND and URND-reseed requesters, collects eight EDN words into one 256-bit result, and returns it to the granted requester with a single-cycle acknowledge. It sits between the RND/URND coordination logic and the EDN interface.

## Interface
- WLEN, 256: width of the returned random word.
- EdnWordWidth, 32: width of one EDN transfer; WLEN/EdnWordWidth = 8 words per fill.

Clock and reset (already decided): reset rst_ni, asynchronous, active-low; clock clk_i.

- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- rnd_req_i  in  1  RND requester wants a WLEN word; held until rnd_ack_o
- rnd_ack_o  out  1  one-cycle pulse, rnd_data_o valid
- rnd_data_o  out  WLEN  fill buffer, valid only while rnd_ack_o=1
- urnd_req_i  in  1  URND reseed requester; held until urnd_ack_o
- urnd_ack_o  out  1  one-cycle pulse, urnd_data_o valid
- urnd_data_o  out  WLEN  fill buffer, valid only while urnd_ack_o=1
- edn_req_o  out  1  EDN request, held high through the whole fill
- edn_ack_i  in  1  EDN word-accepted strobe, one per word
- edn_data_i  in  EdnWordWidth  EDN word, sampled when edn_req_o & edn_ack_i

## Operation
- FSM states: IDLE, FILL, ACK. Reset state IDLE.
- IDLE: if any req, grant and go to FILL. Only rnd: grant RND. Only urnd: grant URND. Both: round-robin, granting the requester not served last. last_grant resets to URND, so RND wins the first tie.
- The grant register holds until ACK completes. Requests arriving during FILL/ACK wait.
- FILL: edn_req_o=1. Each cycle with edn_ack_i=1, write edn_data_i to buf[cnt*32 +: 32] and increment the 3-bit cnt. The handshake with cnt==7 wraps cnt to 0 and moves to ACK.
- ACK: assert ack_o of the granted requester for exactly one cycle. Both data outputs always drive buf. Update last_grant, then go to IDLE.
- Buffer wipe: on ACK->IDLE, buf is cleared to 0. rnd_data_o/urnd_data_o are 0 whenever not in ACK.
- edn_ack_i outside FILL is ignored: no write, no count change.
- A requester dropping req mid-fill is a protocol violation (assertion). The fill still completes and ack still pulses.
- A requester must not re-raise req in the cycle of its own ack unless it wants a new word. Req high in the IDLE cycle after ACK starts a new fill.
- Assertions:
  - rnd_ack_o and urnd_ack_o are never both high.
  - edn_req_o is never low in FILL.
  - req held until ack.

## Timing
- Reset values:
  - edn_req_o=0, rnd_ack_o=0, urnd_ack_o=0.
  - Data outputs all-zero; cnt=0.
- edn_req_o is registered: req seen in IDLE at cycle t gives edn_req_o=1 from t+1.
- With edn_ack_i high every cycle: handshakes in t+1..t+8, ack_o at t+9, IDLE at t+10, next grant possible at t+10.
- Minimum turnaround is 10 cycles per WLEN word. EDN stalls add cycle-for-cycle.
- edn_req_o falls in the cycle after the 8th handshake (ACK) and stays low through IDLE.
- Reset mid-fill returns the block to IDLE immediately:
  - edn_req_o drops asynchronously, buf=0, cnt=0, last_grant=URND.
  - No ack is issued; the requester must re-request.

## Test plan
- Single RND: rnd_req_i=1, EDN returns 0x00000000..0x00000007 on consecutive cycles.
  - rnd_ack_o pulses at t+9 with rnd_data_o = {0x7,0x6,...,0x0} (word0 in bits 31:0).
  - urnd_ack_o stays 0; data is 0 at t+10.
- Simultaneous requests out of reset: RND served first, then URND with a fresh 8 words.
  - Repeat both held: grants alternate RND, URND, RND.
- EDN stalls: edn_ack_i pattern 1,0,0,1,... with 8 words 0xA5A5A5A5+i.
  - Data order is correct; ack is delayed by exactly the stall count; edn_req_o stays high throughout.
- Spurious ack: edn_ack_i=1 with data 0xDEADBEEF while IDLE.
  - Next fill data contains no 0xDEADBEEF; cnt starts at 0.
- Reset mid-fill: assert rst_ni=0 after 4 words.
  - Outputs return to reset values.
  - A following urnd-only request fills 8 new words and urnd_ack_o pulses once.
- URND-only back-to-back: urnd_req_i held high across the ack.
  - Second fill starts the cycle after ACK.
  - Two urnd_ack_o pulses, no rnd_ack_o.
